// File: rtl/alu_slice_reg.sv
// alu_slice_reg: WIDTH-bit ALU with registered result and flags.
// The datapath is a ripple chain of fulladder cells; each result bit is
// selected by a multiplexer8 keyed on the 3-bit op.

// One-bit full adder cell.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  // Sum and carry-out of a single bit position.
  always_comb begin
    s_o  = a_i ^ b_i ^ c_i;
    co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end
endmodule

// Eight-input one-bit multiplexer, index sel_i selects d_i[sel_i].
module multiplexer8 (
  input  logic [2:0] sel_i,
  input  logic [7:0] d_i,
  output logic       y_o
);
  // Select one of eight candidate bits.
  always_comb begin
    y_o = d_i[sel_i];
  end
endmodule

module alu_slice_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic             overflow_d;
  logic             zero_d;
  logic             arith;

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;

  // op[0] both inverts b and injects the +1, so 001 computes a-b.
  assign c[0] = op[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic       bx;
    logic [7:0] cand;

    assign bx = b[i] ^ op[0];

    fulladder u_fa (
      .a_i  (a[i]),
      .b_i  (bx),
      .c_i  (c[i]),
      .s_o  (sum[i]),
      .co_o (c[i+1])
    );

    // Index: 0/1 sum, 2/3 xor, 4 and, 5 nand, 6 nor, 7 or (logic ops use raw b).
    assign cand = {a[i] | b[i],
                   ~(a[i] | b[i]),
                   ~(a[i] & b[i]),
                   a[i] & b[i],
                   a[i] ^ b[i],
                   a[i] ^ b[i],
                   sum[i],
                   sum[i]};

    multiplexer8 u_mux (
      .sel_i (op),
      .d_i   (cand),
      .y_o   (result_d[i])
    );
  end

  // Flags are only meaningful for the adder ops; logic ops clear carry/overflow.
  always_comb begin
    arith      = (op[2:1] == 2'b00);
    carry_d    = arith & c[WIDTH];
    overflow_d = arith & (c[WIDTH] ^ c[WIDTH-1]);
    zero_d     = ~|result_d;
  end

  // Output registers: async clear, capture on enabled edges, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (en) begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_slice_reg.sv
// tb_alu_slice_reg: directed and random checks of alu_slice_reg at WIDTH 8, 2 and 32.
module tb_alu_slice_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic [31:0] a32 = '0, b32 = '0;

  logic [7:0]  r8;
  logic [1:0]  r2;
  logic [31:0] r32;
  logic c8, v8, z8, c2, v2, z2, c32, v32, z32;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  alu_slice_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .op(op), .a(a8), .b(b8),
    .result(r8), .carry(c8), .overflow(v8), .zero(z8)
  );

  alu_slice_reg #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .op(op), .a(a2), .b(b2),
    .result(r2), .carry(c2), .overflow(v2), .zero(z2)
  );

  alu_slice_reg #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .en(en), .op(op), .a(a32), .b(b32),
    .result(r32), .carry(c32), .overflow(v32), .zero(z32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect8(input string tag, input logic [7:0] r, input logic c,
                         input logic v, input logic z);
    check({tag, ".result"},   64'(r8), 64'(r));
    check({tag, ".carry"},    64'(c8), 64'(c));
    check({tag, ".overflow"}, 64'(v8), 64'(v));
    check({tag, ".zero"},     64'(z8), 64'(z));
  endtask

  // Drive one WIDTH=8 vector with en=1 and sample one edge later.
  task automatic apply8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    op = o; a8 = x; b8 = y; en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference ALU built from plain arithmetic on wide integers.
  function automatic void ref_alu(input int unsigned w, input logic [2:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic c,
                                  output logic v, output logic z);
    logic [63:0] m, xa, ya, s;
    m  = (64'd1 << w) - 64'd1;
    xa = {32'd0, x} & m;
    ya = {32'd0, y} & m;
    s  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (o)
      3'b000: begin
        s = xa + ya;
        c = s[w];
        v = (xa[w-1] == ya[w-1]) && (s[w-1] != xa[w-1]);
      end
      3'b001: begin
        s = xa + (~ya & m) + 64'd1;
        c = s[w];
        v = (xa[w-1] != ya[w-1]) && (s[w-1] != xa[w-1]);
      end
      3'b010, 3'b011: s = xa ^ ya;
      3'b100:         s = xa & ya;
      3'b101:         s = ~(xa & ya);
      3'b110:         s = ~(xa | ya);
      default:        s = xa | ya;
    endcase
    s = s & m;
    r = s[31:0];
    z = (s == 64'd0);
  endfunction

  initial begin
    logic [31:0] er;
    logic        ec, ev, ez;

    // Power-on reset.
    #1 reset = 1'b1;
    #11;
    expect8("por", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Add.
    apply8(3'b000, 8'h7F, 8'h01); expect8("add_ovf",  8'h80, 1'b0, 1'b1, 1'b0);
    apply8(3'b000, 8'hFF, 8'h01); expect8("add_wrap", 8'h00, 1'b1, 1'b0, 1'b1);

    // Sub.
    apply8(3'b001, 8'h05, 8'h05); expect8("sub_eq",  8'h00, 1'b1, 1'b0, 1'b1);
    apply8(3'b001, 8'h03, 8'h05); expect8("sub_neg", 8'hFE, 1'b0, 1'b0, 1'b0);

    // Logic ops.
    apply8(3'b010, 8'hCA, 8'h5C); expect8("xor",   8'h96, 1'b0, 1'b0, 1'b0);
    apply8(3'b011, 8'hCA, 8'h5C); expect8("xor_b", 8'h96, 1'b0, 1'b0, 1'b0);
    apply8(3'b100, 8'hCA, 8'h5C); expect8("and",   8'h48, 1'b0, 1'b0, 1'b0);
    apply8(3'b101, 8'hCA, 8'h5C); expect8("nand",  8'hB7, 1'b0, 1'b0, 1'b0);
    apply8(3'b110, 8'hCA, 8'h5C); expect8("nor",   8'h21, 1'b0, 1'b0, 1'b0);
    apply8(3'b111, 8'hCA, 8'h5C); expect8("or",    8'hDE, 1'b0, 1'b0, 1'b0);
    apply8(3'b100, 8'h0F, 8'hF0); expect8("and_z", 8'h00, 1'b0, 1'b0, 1'b1);

    // Enable hold.
    apply8(3'b000, 8'h10, 8'h02); expect8("hold_cap", 8'h12, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0; op = 3'(i + 5); a8 = 8'(8'h33 * (i + 1)); b8 = 8'hA5;
      @(posedge clk);
      #1;
      expect8("hold", 8'h12, 1'b0, 1'b0, 1'b0);
    end
    apply8(3'b001, 8'h20, 8'h01); expect8("hold_rel", 8'h1F, 1'b1, 1'b0, 1'b0);

    // Reset mid-cycle: takes effect without a clock edge.
    apply8(3'b000, 8'h7F, 8'h01); expect8("pre_rst", 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    op = 3'b000; a8 = 8'hFF; b8 = 8'h01; en = 1'b1;
    #2 reset = 1'b1;
    #1 expect8("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 expect8("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Random vectors on all three widths.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      en  = 1'b1;
      op  = 3'($urandom_range(0, 7));
      a8  = 8'($urandom);  b8  = 8'($urandom);
      a2  = 2'($urandom);  b2  = 2'($urandom);
      a32 = $urandom;      b32 = $urandom;
      if (n % 16 == 0) b32 = a32;
      if (n % 16 == 1) b8  = a8;
      @(posedge clk);
      #1;
      ref_alu(8, op, {24'd0, a8}, {24'd0, b8}, er, ec, ev, ez);
      check("rnd8.result", 64'(r8), 64'(er[7:0]));
      check("rnd8.flags",  64'({c8, v8, z8}), 64'({ec, ev, ez}));
      ref_alu(2, op, {30'd0, a2}, {30'd0, b2}, er, ec, ev, ez);
      check("rnd2.result", 64'(r2), 64'(er[1:0]));
      check("rnd2.flags",  64'({c2, v2, z2}), 64'({ec, ev, ez}));
      ref_alu(32, op, a32, b32, er, ec, ev, ez);
      check("rnd32.result", 64'(r32), 64'(er));
      check("rnd32.flags",  64'({c32, v32, z32}), 64'({ec, ev, ez}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
